fpu_issue_ctrl: RTL and testbench

Sequential front-end that issues operations to the combinational double-precision FPU core (`float_top`: opcode, A, B in; Y out). It accepts tagged requests over a valid/ready channel and buffers them in a small FIFO. Each operation is held on the FPU inputs for a fixed number of settle cycles, treated as a multicycle path. The result is then captured and returned in order over a valid/ready response channel.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_issue_fifo.sv | 50 +++++
 rtl/fpu_issue_ctrl.sv | 110 +++++++++++
 tb/tb_fpu_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, FSM encoding, flag indices and double-precision field helpers for the FPU issue path.
package fpu_pkg;
  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

  localparam int DP_SIGN_W = 1;
  localparam int DP_EXP_W  = 11;
  localparam int DP_MANT_W = 52;

  // Classifies a double from its magnitude bits; the sign never affects the flags.
  function automatic logic [2:0] dp_flags(input logic [DP_EXP_W+DP_MANT_W-1:0] mag);
    logic [DP_EXP_W-1:0] e;
    logic [DP_MANT_W-1:0] m;
    logic [2:0] f;
    e = mag[DP_EXP_W+DP_MANT_W-1:DP_MANT_W];
    m = mag[DP_MANT_W-1:0];
    f = '0;
    f[FLAG_ZERO] = (e == '0) && (m == '0);
    f[FLAG_INF]  = (&e) && (m == '0);
    f[FLAG_NAN]  = (&e) && (m != '0);
    return f;
  endfunction
endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: synchronous request FIFO; full is registered so it never depends on a same-cycle pop.
module fpu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;

  assign count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  assign dout_o  = mem[rd_q];
  assign full_o  = full_q;
  assign empty_o = count_q == '0;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      full_q  <= count_d == (AW+1)'(DEPTH);
    end
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: buffers tagged FPU requests, holds each on the FPU for SETTLE cycles, returns results in order.
// Optional result classification flags are built when FPU_ISSUE_FLAGS_EN is defined.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_opcode,
  output logic [63:0]      fpu_a,
  output logic [63:0]      fpu_b,
  input  logic [63:0]      fpu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef FPU_ISSUE_FLAGS_EN
  , output logic [2:0]     rsp_flags
`endif
);
  localparam int EW = 2 + 64 + 64 + TAG_W;

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be within 1..15");
  end

  logic [EW-1:0]          head;
  logic                   full, empty, push, pop, fire, done;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]             state_q, state_d, op_q;
  logic [3:0]             cnt_q;
  logic [63:0]            a_q, b_q, result_q;
  logic [TAG_W-1:0]       tag_q, rtag_q;
  logic                   rsp_valid_q;

  fpu_issue_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({req_op, req_a, req_b, req_tag}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign fire       = rsp_valid_q && rsp_ready;
  // A pop happens from IDLE, or on the response handshake so issue continues back-to-back.
  assign pop        = !empty && (state_q == ST_IDLE || (state_q == ST_RESP && fire));
  assign done       = state_q == ST_EXEC && cnt_q == 4'd1;
  assign state_d    = pop ? ST_EXEC : done ? ST_RESP : (state_q == ST_RESP && fire) ? ST_IDLE : state_q;
  assign busy       = state_q != ST_IDLE || count != '0;
  assign fpu_opcode = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_tag    = rtag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      rtag_q      <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        {op_q, a_q, b_q, tag_q} <= head;
        cnt_q <= 4'(SETTLE);
      end else if (state_q == ST_EXEC) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (done) begin
        result_q    <= fpu_y;
        rtag_q      <= tag_q;
        rsp_valid_q <= 1'b1;
      end else if (fire) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef FPU_ISSUE_FLAGS_EN
  logic [2:0] flags_q;
  assign rsp_flags = flags_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else if (done) flags_q <= dp_flags(fpu_y[62:0]);
  end
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed and randomized checks of fpu_issue_ctrl against an in-order response model.
// A real-arithmetic FPU model stands in for float_top; flag checks build when FPU_ISSUE_FLAGS_EN is defined.
module tb_fpu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [1:0]  fpu_opcode;
  logic [63:0] fpu_a, fpu_b, fpu_y;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        busy;
`ifdef FPU_ISSUE_FLAGS_EN
  logic [2:0]  rsp_flags;
`endif

  int checks = 0, failures = 0, ncyc = 0;
  logic pushed = 1'b0;
  logic [67:0] exp_q[$];
  logic [3:0]  got_tags[$];

  fpu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_opcode(fpu_opcode), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_y(fpu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .busy(busy)
`ifdef FPU_ISSUE_FLAGS_EN
    , .rsp_flags(rsp_flags)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fpu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    real x, y, r;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    r = op == 2'b00 ? x + y : op == 2'b01 ? x - y : op == 2'b10 ? x * y : x / y;
    return $realtobits(r);
  endfunction

  always_comb fpu_y = fpu_ref(fpu_opcode, fpu_a, fpu_b);

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input real a, input real b, input logic [3:0] tag);
    req_op = op;
    req_a = $realtobits(a);
    req_b = $realtobits(b);
    req_tag = tag;
    req_valid = 1'b1;
  endtask

  // One clock: book handshakes into the model, advance, and retire an accepted request.
  task automatic cyc();
    logic p, f;
    logic [67:0] e;
    p = req_valid && req_ready;
    f = rsp_valid && rsp_ready;
    if (p) exp_q.push_back({req_tag, fpu_ref(req_op, req_a, req_b)});
    if (f) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL rsp_unexpected observed_tag=%h expected=none", rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rsp_tag", 64'(rsp_tag), 64'(e[67:64]));
        check("rsp_result", rsp_result, e[63:0]);
        got_tags.push_back(rsp_tag);
      end
    end
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    pushed = p;
    if (p) req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!rsp_valid && n < lim) begin
      cyc();
      n++;
    end
    check("wait_valid", 64'(rsp_valid), 64'd1);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy || req_valid) && n < lim) begin
      cyc();
      n++;
    end
    check("drain_done", 64'(exp_q.size() != 0 || busy || req_valid), 64'd0);
  endtask

  task automatic single(input logic [1:0] op, input real a, input real b, input logic [3:0] tag, input logic [63:0] exp);
    logic early = 1'b0;
    rsp_ready = 1'b1;
    send(op, a, b, tag);
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      early |= rsp_valid;
    end
    check("lat_early", 64'(early), 64'd0);
    cyc();
    check("lat_valid", 64'(rsp_valid), 64'd1);
    check("single_result", rsp_result, exp);
    check("single_tag", 64'(rsp_tag), 64'(tag));
    check("single_busy", 64'(busy), 64'd1);
    cyc();
    check("single_valid_clr", 64'(rsp_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int acc, unstable, t1, t2, seen;
    logic [63:0] s_res, s_a, s_b, r1;
    logic [3:0] s_tag;
    logic [1:0] s_op;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fpu_a", fpu_a, 64'd0);
    check("rst_result", rsp_result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single(2'b00, 1.0, 2.0, 4'd5, 64'h4008000000000000);

    // Fill: five accepted, sixth blocked until the first response frees a slot.
    got_tags.delete();
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(2'b00, $itor(i), 1.0, 4'(i));
      cyc();
      acc += int'(pushed);
    end
    check("fill_accepted", 64'(acc), 64'd5);
    check("fill_ready_low", 64'(req_ready), 64'd0);
    check("fill_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    cyc();
    check("full_no_push", 64'(pushed), 64'd0);
    check("full_ready_rise", 64'(req_ready), 64'd1);
    drain(200);
    check("fill_count", 64'(got_tags.size()), 64'd6);
    for (int i = 0; i < 6 && i < got_tags.size(); i++) check("fill_order", 64'(got_tags[i]), 64'(i));

    // Backpressure with a second entry queued behind.
    rsp_ready = 1'b0;
    send(2'b10, 1.5, 4.0, 4'd7);
    cyc();
    send(2'b00, 1.0, 1.0, 4'd8);
    cyc();
    wait_valid(20);
    s_res = rsp_result; s_tag = rsp_tag; s_a = fpu_a; s_b = fpu_b; s_op = fpu_opcode;
    check("bp_result", s_res, 64'h4018000000000000);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!rsp_valid || rsp_result !== s_res || rsp_tag !== s_tag || fpu_a !== s_a || fpu_b !== s_b || fpu_opcode !== s_op) unstable++;
    end
    check("bp_stable", 64'(unstable), 64'd0);
    rsp_ready = 1'b1;
    cyc();
    check("bp_pop_a", fpu_a, 64'h3FF0000000000000);
    check("bp_pop_op", 64'(fpu_opcode), 64'd0);
    drain(50);

    // Back-to-back mul then div.
    rsp_ready = 1'b1;
    send(2'b10, 3.0, 2.0, 4'd1);
    cyc();
    send(2'b11, 6.0, 2.0, 4'd2);
    cyc();
    wait_valid(20);
    t1 = ncyc;
    r1 = rsp_result;
    cyc();
    wait_valid(20);
    t2 = ncyc;
    check("b2b_mul", r1, 64'h4018000000000000);
    check("b2b_div", rsp_result, 64'h4008000000000000);
    check("b2b_spacing", 64'(t2 - t1), 64'd4);
    drain(50);

    // Asynchronous reset in the middle of EXEC with one entry still queued.
    send(2'b00, 1.0, 1.0, 4'd3);
    cyc();
    send(2'b00, 2.0, 1.0, 4'd4);
    cyc();
    cyc();
    cyc();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      seen += int'(rsp_valid || busy);
    end
    check("arst_discard", 64'(seen), 64'd0);
    single(2'b00, 1.0, 2.0, 4'd9, 64'h4008000000000000);

`ifdef FPU_ISSUE_FLAGS_EN
    single(2'b01, 2.0, 2.0, 4'd10, 64'd0);
    check("flags_zero", 64'(rsp_flags), 64'd1);
    rsp_ready = 1'b1;
    req_op = 2'b00; req_a = 64'h7FF8000000000000; req_b = 64'h3FF0000000000000; req_tag = 4'd11;
    req_valid = 1'b1;
    cyc();
    wait_valid(20);
    check("flags_nan", 64'(rsp_flags[2]), 64'd1);
    drain(20);
`endif

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 400; i++) begin
      rsp_ready = $urandom_range(0, 3) != 0;
      if (!req_valid && $urandom_range(0, 1) == 1)
        send(2'($urandom_range(0, 3)), $itor($urandom_range(0, 200)) - 100.0, $itor($urandom_range(1, 64)), 4'($urandom_range(0, 15)));
      cyc();
    end
    req_valid = 1'b0;
    drain(300);
    check("rand_model_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
